axis_keep_packer: RTL
=====================

Name: axis_keep_packer

Overview:
- Sits directly downstream of the no-ID SLIP decoder.
- Consumes its AXI-S stream, in which an END symbol arrives as a null beat (TKEEP=0, TLAST=1).
- Produces a packed AXI-S stream with no TKEEP: every output beat carries a real symbol, and TLAST is on the last real symbol of each packet.
- Downstream consumers without TKEEP support attach here. Empty packets (END with no preceding data) are dropped and flagged.

Parameters:
SYMBOL_WIDTH  8  width of tdata in bits

Ports:
i_clk  input  1  clock
i_rst  input  1  reset; synchronous, active-high
i_s_axis_tvalid  input  1  input beat valid
o_s_axis_tready  output  1  input ready
i_s_axis_tdata  input  SYMBOL_WIDTH  input symbol
i_s_axis_tkeep  input  1  1 = real symbol, 0 = null beat
i_s_axis_tlast  input  1  packet end marker
o_m_axis_tvalid  output  1  output beat valid (registered)
i_m_axis_tready  input  1  output ready
o_m_axis_tdata  output  SYMBOL_WIDTH  output symbol (registered)
o_m_axis_tlast  output  1  last symbol of packet (registered)
o_empty_pkt  output  1  1-cycle pulse: empty packet dropped
o_null_beat  output  1  1-cycle pulse: stray null beat (TKEEP=0, TLAST=0) dropped

Behaviour:
- Clock and reset: single clock i_clk; i_rst is synchronous and active-high.
- Storage has two registers:
  - H (hold): h_valid, h_data, h_last. Holds a symbol whose lastness may still be unknown.
  - O (output): o_valid, o_data, o_last. Drives the o_m_axis_* ports directly.
- Reset values: h_valid=0, h_last=0, o_valid=0; o_m_axis_tvalid=0, o_m_axis_tlast=0, o_m_axis_tdata=0; o_empty_pkt=0, o_null_beat=0. A reset mid-packet discards H and O contents with no partial output.
- Handshake:
  - o_free = !o_valid || i_m_axis_tready.
  - o_s_axis_tready = o_free && !(h_valid && h_last). Combinational; it does not depend on i_s_axis_tvalid.
  - Input accept: acc = i_s_axis_tvalid && o_s_axis_tready.
  - Output transfer: o_valid && i_m_axis_tready. On transfer with no new load, o_valid <= 0.
  - AXI-S rules: o_m_axis_tvalid never drops and data never changes while stalled (o_valid && !i_m_axis_tready).
- Flush: if h_valid && h_last && o_free, then O <= {h_data, last=1}, h_valid <= 0, h_last <= 0. No input is accepted that cycle.
- On acc, exactly one row applies:
  - keep=1, last=0, H empty: H <= {data, last=0}.
  - keep=1, last=0, H full: O <= {h_data, 0}, H <= {data, 0}.
  - keep=1, last=1, H empty: O <= {data, 1}.
  - keep=1, last=1, H full: O <= {h_data, 0}, H <= {data, 1}. The flush follows on a later cycle.
  - keep=0, last=1, H full: O <= {h_data, 1}, h_valid <= 0.
  - keep=0, last=1, H empty: nothing is output; o_empty_pkt pulses next cycle.
  - keep=0, last=0: beat dropped, H unchanged; o_null_beat pulses next cycle.
- Latency:
  - A symbol reaches O one cycle after the accept of the following beat that resolves its lastness.
  - Single-symbol packet (one real beat then END): O valid 1 cycle after the END accept.
- Throughput: with i_m_axis_tready=1, one input beat per cycle is sustained. The only bubble is the flush cycle after a keep=1, last=1 beat that arrives with H full.
- Output O holds at most one beat; no further buffering.
- Pulse outputs are registered, asserted for exactly 1 cycle per event, and clear at reset.
- Ordering: symbol order is preserved exactly; no symbol is duplicated or lost except the dropped null beats.

Test Plan:
- Basic packet: input keep=1 beats 0x11, 0x22, 0x33, then keep=0/last=1; sink always ready → output 0x11/L0, 0x22/L0, 0x33/L1. The 0x33 beat is valid 1 cycle after END is accepted.
- Back-to-back with tlast on data: input 0xA1, then 0xA2 with keep=1/last=1, then 0xB1, then END → output 0xA1/L0, 0xA2/L1, 0xB1/L1. One tready=0 flush cycle occurs after 0xA2.
- Empty packets: two consecutive END beats with no data → no output beats, o_empty_pkt pulses twice; a following packet 0x55, END gives 0x55/L1.
- Backpressure: hold i_m_axis_tready=0 for 5 cycles mid-packet, then random 50% → tdata/tlast stable while stalled; sequence matches the golden model with no loss or duplication across 1000 random packets (lengths 0–20).
- Stray null beat: 0x01, keep=0/last=0, 0x02, END → output 0x01/L0, 0x02/L1; o_null_beat pulses once.
- Reset mid-packet: 0x77 held in H, assert i_rst for 1 cycle → o_m_axis_tvalid=0 the next cycle; a subsequent 0x88, END gives only 0x88/L1, and 0x77 never appears.

Source files
------------

// File: rtl/axis_keep_packer.sv
// Repacks a TKEEP-qualified AXI-S stream (END = null beat with TLAST) into a dense
// stream without TKEEP, where TLAST sits on the last real symbol of each packet.
module axis_keep_packer #(
  parameter int SYMBOL_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_s_axis_tvalid,
  output logic                    o_s_axis_tready,
  input  logic [SYMBOL_WIDTH-1:0] i_s_axis_tdata,
  input  logic                    i_s_axis_tkeep,
  input  logic                    i_s_axis_tlast,
  output logic                    o_m_axis_tvalid,
  input  logic                    i_m_axis_tready,
  output logic [SYMBOL_WIDTH-1:0] o_m_axis_tdata,
  output logic                    o_m_axis_tlast,
  output logic                    o_empty_pkt,
  output logic                    o_null_beat
);

  typedef struct packed {
    logic                    vld;
    logic                    last;
    logic [SYMBOL_WIDTH-1:0] data;
  } slot_t;

  // h_q holds a symbol until the next beat tells us whether it ends the packet
  slot_t h_q, h_d;
  slot_t o_q, o_d;
  logic  empty_q, empty_d;
  logic  null_q, null_d;

  logic o_free, h_done, flush, acc;

  assign o_free          = !o_q.vld || i_m_axis_tready;
  assign h_done          = h_q.vld && h_q.last;
  assign flush           = h_done && o_free;
  assign o_s_axis_tready = o_free && !h_done;
  assign acc             = i_s_axis_tvalid && o_s_axis_tready;

  always_comb begin
    h_d     = h_q;
    o_d     = o_q;
    empty_d = 1'b0;
    null_d  = 1'b0;
    if (o_q.vld && i_m_axis_tready) o_d.vld = 1'b0;
    if (flush) begin
      o_d      = '{vld: 1'b1, last: 1'b1, data: h_q.data};
      h_d.vld  = 1'b0;
      h_d.last = 1'b0;
    end else if (acc) begin
      case ({i_s_axis_tkeep, i_s_axis_tlast})
        2'b10: begin
          if (h_q.vld) o_d = '{vld: 1'b1, last: 1'b0, data: h_q.data};
          h_d = '{vld: 1'b1, last: 1'b0, data: i_s_axis_tdata};
        end
        2'b11: begin
          if (h_q.vld) begin
            // both symbols are resolved; the held one goes now, this one flushes next
            o_d = '{vld: 1'b1, last: 1'b0, data: h_q.data};
            h_d = '{vld: 1'b1, last: 1'b1, data: i_s_axis_tdata};
          end else begin
            o_d = '{vld: 1'b1, last: 1'b1, data: i_s_axis_tdata};
          end
        end
        2'b01: begin
          if (h_q.vld) begin
            o_d      = '{vld: 1'b1, last: 1'b1, data: h_q.data};
            h_d.vld  = 1'b0;
            h_d.last = 1'b0;
          end else begin
            empty_d = 1'b1;
          end
        end
        default: null_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_q     <= '0;
      o_q     <= '0;
      empty_q <= 1'b0;
      null_q  <= 1'b0;
    end else begin
      h_q     <= h_d;
      o_q     <= o_d;
      empty_q <= empty_d;
      null_q  <= null_d;
    end
  end

  assign o_m_axis_tvalid = o_q.vld;
  assign o_m_axis_tdata  = o_q.data;
  assign o_m_axis_tlast  = o_q.last;
  assign o_empty_pkt     = empty_q;
  assign o_null_beat     = null_q;

endmodule
